// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encodings,
// interrupt codes, mstatus/mie bit positions and writable masks.
package csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // Bit positions of the one-hot select produced by the index decoder.
    localparam int SEL_MSTATUS   = 0;
    localparam int SEL_MISA      = 1;
    localparam int SEL_MIE       = 2;
    localparam int SEL_MTVEC     = 3;
    localparam int SEL_MSCRATCH  = 4;
    localparam int SEL_MEPC      = 5;
    localparam int SEL_MCAUSE    = 6;
    localparam int SEL_MTVAL     = 7;
    localparam int SEL_MIP       = 8;
    localparam int SEL_MHARTID   = 9;
    localparam int SEL_MCYCLE    = 10;
    localparam int SEL_MCYCLEH   = 11;
    localparam int SEL_MINSTRET  = 12;
    localparam int SEL_MINSTRETH = 13;
    localparam int NUM_SEL       = 14;

    localparam logic [30:0] IRQ_CODE_SW    = 31'd3;
    localparam logic [30:0] IRQ_CODE_TIMER = 31'd7;
    localparam logic [30:0] IRQ_CODE_EXT   = 31'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIE_MSIE = 3;
    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    localparam logic [31:0] MIE_WMASK        = 32'h0000_0888;
    localparam logic [31:0] MEPC_WMASK       = 32'hFFFF_FFFC;
    localparam logic [31:0] MTVEC_WMASK_VEC  = 32'hFFFF_FFFD;
    localparam logic [31:0] MTVEC_WMASK_BASE = 32'hFFFF_FFFC;

endpackage

// File: rtl/csr_index_decoder.sv
// Maps a 12-bit CSR address onto a one-hot register select.
// Counter addresses decode only when CSR_COUNTERS_EN is defined.
module csr_index_decoder
    import csr_pkg::*;
(
    input  logic [11:0]        addr_i,
    output logic [NUM_SEL-1:0] sel_o,
    output logic               valid_o,
    output logic               readOnly_o
);

    always_comb begin
        sel_o      = '0;
        readOnly_o = 1'b0;
        case (addr_i)
            ADDR_MSTATUS:  sel_o[SEL_MSTATUS]  = 1'b1;
            ADDR_MISA:     sel_o[SEL_MISA]     = 1'b1;
            ADDR_MIE:      sel_o[SEL_MIE]      = 1'b1;
            ADDR_MTVEC:    sel_o[SEL_MTVEC]    = 1'b1;
            ADDR_MSCRATCH: sel_o[SEL_MSCRATCH] = 1'b1;
            ADDR_MEPC:     sel_o[SEL_MEPC]     = 1'b1;
            ADDR_MCAUSE:   sel_o[SEL_MCAUSE]   = 1'b1;
            ADDR_MTVAL:    sel_o[SEL_MTVAL]    = 1'b1;
            ADDR_MIP:      sel_o[SEL_MIP]      = 1'b1;
            ADDR_MHARTID: begin
                sel_o[SEL_MHARTID] = 1'b1;
                readOnly_o         = 1'b1;
            end
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    sel_o[SEL_MCYCLE]    = 1'b1;
            ADDR_MCYCLEH:   sel_o[SEL_MCYCLEH]   = 1'b1;
            ADDR_MINSTRET:  sel_o[SEL_MINSTRET]  = 1'b1;
            ADDR_MINSTRETH: sel_o[SEL_MINSTRETH] = 1'b1;
`endif
            default: ;
        endcase
        valid_o = |sel_o;
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR read/modify/write, trap entry, mret and interrupt
// request generation. Define CSR_COUNTERS_EN to add mcycle/minstret.
module csr_file
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [XLEN-1:0] MISA_VALUE  = 32'h4000_0100,
    parameter bit              VECTORED    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            instr_retired,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    output logic            irq_pending,
    output logic [XLEN-1:0] irq_cause,
    output logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] epc_out
);

    localparam logic [XLEN-1:0] MTVEC_WMASK = VECTORED ? MTVEC_WMASK_VEC : MTVEC_WMASK_BASE;

    logic [NUM_SEL-1:0] sel;
    logic               addrValid;
    logic               addrReadOnly;
    csr_op_e            op;
    logic               writeReq;
    logic               doWrite;
    logic [XLEN-1:0]    oldValue;
    logic [XLEN-1:0]    writeValue;
    logic [XLEN-1:0]    mstatusRd;
    logic [XLEN-1:0]    mipRd;
    logic [XLEN-1:0]    mtvecRd;
    logic [XLEN-1:0]    mtvecBase;
    logic [2:0]         pendingSet;

    logic            mstatusMie_q, mstatusMie_d;
    logic            mstatusMpie_q, mstatusMpie_d;
    logic [XLEN-1:0] mieReg_q, mieReg_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [2:0]      mip_q, mip_d;
    logic            irqPending_q, irqPending_d;
    logic [XLEN-1:0] irqCause_q, irqCause_d;

    csr_index_decoder u_decoder (
        .addr_i     (csr_addr),
        .sel_o      (sel),
        .valid_o    (addrValid),
        .readOnly_o (addrReadOnly)
    );

    // RS/RC with a zero operand is a pure read, so it never counts as a write.
    assign op          = csr_op_e'(csr_op);
    assign writeReq    = (op == CSR_OP_RW) ||
                         (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (csr_wdata != '0));
    assign csr_illegal = (op != CSR_OP_NONE) && (!addrValid || (addrReadOnly && writeReq));
    assign doWrite     = writeReq && !csr_illegal && !trap_valid && !mret;

    always_comb begin
        mstatusRd                               = '0;
        mstatusRd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatusRd[MSTATUS_MPIE]                 = mstatusMpie_q;
        mstatusRd[MSTATUS_MIE]                  = mstatusMie_q;
        mipRd                                   = '0;
        mipRd[MIE_MEIE]                         = mip_q[2];
        mipRd[MIE_MTIE]                         = mip_q[1];
        mipRd[MIE_MSIE]                         = mip_q[0];
    end

    assign mtvecRd = mtvec_q & MTVEC_WMASK;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    // A write to either half replaces the whole counter's increment that cycle.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instr_retired};
        if (doWrite && sel[SEL_MCYCLE])    mcycle_d   = {mcycle_q[63:32], writeValue};
        if (doWrite && sel[SEL_MCYCLEH])   mcycle_d   = {writeValue, mcycle_q[31:0]};
        if (doWrite && sel[SEL_MINSTRET])  minstret_d = {minstret_q[63:32], writeValue};
        if (doWrite && sel[SEL_MINSTRETH]) minstret_d = {writeValue, minstret_q[31:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`else
    logic unusedCounterInputs;
    assign unusedCounterInputs = ^{instr_retired, sel[SEL_MINSTRETH:SEL_MCYCLE]};
`endif

    always_comb begin
        oldValue = '0;
        if (sel[SEL_MSTATUS])  oldValue = mstatusRd;
        if (sel[SEL_MISA])     oldValue = MISA_VALUE;
        if (sel[SEL_MIE])      oldValue = mieReg_q;
        if (sel[SEL_MTVEC])    oldValue = mtvecRd;
        if (sel[SEL_MSCRATCH]) oldValue = mscratch_q;
        if (sel[SEL_MEPC])     oldValue = mepc_q;
        if (sel[SEL_MCAUSE])   oldValue = mcause_q;
        if (sel[SEL_MTVAL])    oldValue = mtval_q;
        if (sel[SEL_MIP])      oldValue = mipRd;
`ifdef CSR_COUNTERS_EN
        if (sel[SEL_MCYCLE])    oldValue = mcycle_q[31:0];
        if (sel[SEL_MCYCLEH])   oldValue = mcycle_q[63:32];
        if (sel[SEL_MINSTRET])  oldValue = minstret_q[31:0];
        if (sel[SEL_MINSTRETH]) oldValue = minstret_q[63:32];
`endif
    end

    assign csr_rdata = addrValid ? oldValue : '0;

    always_comb begin
        case (op)
            CSR_OP_RW: writeValue = csr_wdata;
            CSR_OP_RS: writeValue = oldValue | csr_wdata;
            CSR_OP_RC: writeValue = oldValue & ~csr_wdata;
            default:   writeValue = oldValue;
        endcase
    end

    // Trap entry beats mret beats a CSR write; the loser is dropped completely.
    always_comb begin
        mstatusMie_d  = mstatusMie_q;
        mstatusMpie_d = mstatusMpie_q;
        mieReg_d      = mieReg_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        if (trap_valid) begin
            mepc_d        = trap_pc & MEPC_WMASK;
            mcause_d      = trap_cause;
            mtval_d       = trap_tval;
            mstatusMpie_d = mstatusMie_q;
            mstatusMie_d  = 1'b0;
        end else if (mret) begin
            mstatusMie_d  = mstatusMpie_q;
            mstatusMpie_d = 1'b1;
        end else if (doWrite) begin
            if (sel[SEL_MSTATUS]) begin
                mstatusMie_d  = writeValue[MSTATUS_MIE];
                mstatusMpie_d = writeValue[MSTATUS_MPIE];
            end
            if (sel[SEL_MIE])      mieReg_d   = writeValue & MIE_WMASK;
            if (sel[SEL_MTVEC])    mtvec_d    = writeValue & MTVEC_WMASK;
            if (sel[SEL_MSCRATCH]) mscratch_d = writeValue;
            if (sel[SEL_MEPC])     mepc_d     = writeValue & MEPC_WMASK;
            if (sel[SEL_MCAUSE])   mcause_d   = writeValue;
            if (sel[SEL_MTVAL])    mtval_d    = writeValue;
        end
    end

    // Priority among pending lines is external, then software, then timer.
    always_comb begin
        mip_d        = {irq_ext, irq_timer, irq_sw};
        pendingSet   = mip_q & {mieReg_q[MIE_MEIE], mieReg_q[MIE_MTIE], mieReg_q[MIE_MSIE]};
        irqPending_d = mstatusMie_q && (pendingSet != 3'b000);
        irqCause_d   = '0;
        if (irqPending_d) begin
            if (pendingSet[2])      irqCause_d = {1'b1, IRQ_CODE_EXT};
            else if (pendingSet[0]) irqCause_d = {1'b1, IRQ_CODE_SW};
            else                    irqCause_d = {1'b1, IRQ_CODE_TIMER};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatusMie_q  <= 1'b0;
            mstatusMpie_q <= 1'b0;
            mieReg_q      <= '0;
            mtvec_q       <= MTVEC_RESET;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mip_q         <= '0;
            irqPending_q  <= 1'b0;
            irqCause_q    <= '0;
        end else begin
            mstatusMie_q  <= mstatusMie_d;
            mstatusMpie_q <= mstatusMpie_d;
            mieReg_q      <= mieReg_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mip_q         <= mip_d;
            irqPending_q  <= irqPending_d;
            irqCause_q    <= irqCause_d;
        end
    end

    assign mtvecBase   = {mtvecRd[XLEN-1:2], 2'b00};
    assign trap_target = (mtvecRd[0] && trap_cause[XLEN-1])
                       ? mtvecBase + {trap_cause[XLEN-3:0], 2'b00}
                       : mtvecBase;
    assign epc_out     = mepc_q;
    assign irq_pending = irqPending_q;
    assign irq_cause   = irqCause_q;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus queues expected outputs, a negedge
// monitor pops and compares them. Counter checks follow CSR_COUNTERS_EN.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        instr_retired;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_sw;
    logic        irq_pending;
    logic [31:0] irq_cause;
    logic [31:0] trap_target;
    logic [31:0] epc_out;

    typedef enum int {SIG_RDATA, SIG_ILLEGAL, SIG_PENDING, SIG_CAUSE, SIG_TARGET, SIG_EPC} sig_e;
    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] value;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monExp;
    logic [31:0] monActual;
    int          checkCount = 0;
    int          failCount  = 0;

    always #5 clk = ~clk;

    csr_file #(
        .XLEN        (32),
        .MTVEC_RESET (32'h0000_0200),
        .MISA_VALUE  (32'h4000_0100),
        .VECTORED    (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_addr      (csr_addr),
        .csr_op        (csr_op),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .csr_illegal   (csr_illegal),
        .trap_valid    (trap_valid),
        .trap_cause    (trap_cause),
        .trap_pc       (trap_pc),
        .trap_tval     (trap_tval),
        .mret          (mret),
        .instr_retired (instr_retired),
        .irq_ext       (irq_ext),
        .irq_timer     (irq_timer),
        .irq_sw        (irq_sw),
        .irq_pending   (irq_pending),
        .irq_cause     (irq_cause),
        .trap_target   (trap_target),
        .epc_out       (epc_out)
    );

    // Monitor: every expectation queued during a cycle is compared at its negedge.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            case (monExp.sig)
                SIG_RDATA:   monActual = csr_rdata;
                SIG_ILLEGAL: monActual = {31'd0, csr_illegal};
                SIG_PENDING: monActual = {31'd0, irq_pending};
                SIG_CAUSE:   monActual = irq_cause;
                SIG_TARGET:  monActual = trap_target;
                default:     monActual = epc_out;
            endcase
            checkCount++;
            if (monActual !== monExp.value) begin
                failCount++;
                $display("[TB] FAIL %s: actual=%h required=%h", monExp.name, monActual, monExp.value);
            end
        end
    end

    task automatic applyStimulus(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata);
        csr_addr  = addr;
        csr_op    = op;
        csr_wdata = wdata;
    endtask

    task automatic checkOutput(input string name, input sig_e sig, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.sig   = sig;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readCsr(input string name, input logic [11:0] addr, input logic [31:0] value);
        applyStimulus(addr, 2'b00, 32'd0);
        checkOutput(name, SIG_RDATA, value);
        tick();
    endtask

    task automatic writeCsr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata);
        applyStimulus(addr, op, wdata);
        tick();
        applyStimulus(addr, 2'b00, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(12'h000, 2'b00, 32'd0);
        trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
        mret = 1'b0; instr_retired = 1'b0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        $display("[TB] reset values");
        checkOutput("reset_pending", SIG_PENDING, 32'd0);
        checkOutput("reset_cause", SIG_CAUSE, 32'd0);
        readCsr("reset_mstatus", 12'h300, 32'h0000_1800);
        readCsr("reset_mtvec", 12'h305, 32'h0000_0200);
        readCsr("reset_misa", 12'h301, 32'h4000_0100);
        readCsr("reset_mhartid", 12'hF14, 32'd0);

        $display("[TB] set/clear/write");
        applyStimulus(12'h300, 2'b10, 32'h8);
        checkOutput("rs_old_value", SIG_RDATA, 32'h0000_1800);
        checkOutput("rs_legal", SIG_ILLEGAL, 32'd0);
        tick();
        readCsr("rs_mstatus", 12'h300, 32'h0000_1808);
        writeCsr(12'h300, 2'b11, 32'h8);
        readCsr("rc_mstatus", 12'h300, 32'h0000_1800);
        writeCsr(12'h341, 2'b01, 32'h1003);
        checkOutput("mepc_epc_out", SIG_EPC, 32'h0000_1000);
        readCsr("rw_mepc", 12'h341, 32'h0000_1000);

        $display("[TB] illegal and masked writes");
        applyStimulus(12'h7C0, 2'b01, 32'hFFFF_FFFF);
        checkOutput("unmapped_illegal", SIG_ILLEGAL, 32'd1);
        checkOutput("unmapped_rdata", SIG_RDATA, 32'd0);
        tick();
        readCsr("after_illegal_mstatus", 12'h300, 32'h0000_1800);
        applyStimulus(12'hF14, 2'b01, 32'h5);
        checkOutput("mhartid_rw_illegal", SIG_ILLEGAL, 32'd1);
        tick();
        applyStimulus(12'hF14, 2'b10, 32'd0);
        checkOutput("mhartid_rs0_legal", SIG_ILLEGAL, 32'd0);
        checkOutput("mhartid_rs0_rdata", SIG_RDATA, 32'd0);
        tick();
        applyStimulus(12'hF14, 2'b11, 32'd1);
        checkOutput("mhartid_rc_illegal", SIG_ILLEGAL, 32'd1);
        tick();
        writeCsr(12'h344, 2'b01, 32'hFFFF_FFFF);
        readCsr("mip_write_ignored", 12'h344, 32'd0);
        writeCsr(12'h301, 2'b01, 32'd0);
        readCsr("misa_write_ignored", 12'h301, 32'h4000_0100);
        writeCsr(12'h304, 2'b01, 32'hFFFF_FFFF);
        readCsr("mie_mask", 12'h304, 32'h0000_0888);
        writeCsr(12'h300, 2'b01, 32'hFFFF_FFFF);
        readCsr("mstatus_mask", 12'h300, 32'h0000_1888);
        writeCsr(12'h300, 2'b01, 32'd0);
        writeCsr(12'h305, 2'b01, 32'hFFFF_FFFF);
        readCsr("mtvec_mask", 12'h305, 32'hFFFF_FFFD);
        writeCsr(12'h305, 2'b01, 32'h0000_1001);
`ifndef CSR_COUNTERS_EN
        applyStimulus(12'hB00, 2'b01, 32'd1);
        checkOutput("mcycle_absent_illegal", SIG_ILLEGAL, 32'd1);
        tick();
`endif

        $display("[TB] trap entry and mret");
        writeCsr(12'h300, 2'b10, 32'h8);
        trap_cause = 32'h0000_0002;
        checkOutput("target_exception", SIG_TARGET, 32'h0000_1000);
        tick();
        trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h102; trap_tval = 32'hDEAD;
        checkOutput("target_vectored", SIG_TARGET, 32'h0000_101C);
        tick();
        trap_valid = 1'b0;
        checkOutput("trap_epc_out", SIG_EPC, 32'h0000_0100);
        readCsr("trap_mepc", 12'h341, 32'h0000_0100);
        readCsr("trap_mcause", 12'h342, 32'h8000_0007);
        readCsr("trap_mtval", 12'h343, 32'h0000_DEAD);
        readCsr("trap_mstatus", 12'h300, 32'h0000_1880);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        readCsr("mret_mstatus", 12'h300, 32'h0000_1888);
        mret = 1'b1;
        applyStimulus(12'h340, 2'b01, 32'h1234);
        tick();
        mret = 1'b0;
        readCsr("mret_beats_write", 12'h340, 32'd0);

        $display("[TB] interrupt path");
        applyStimulus(12'h344, 2'b00, 32'd0);
        irq_timer = 1'b1; irq_ext = 1'b1;
        checkOutput("irq_c0_pending", SIG_PENDING, 32'd0);
        checkOutput("irq_c0_mip", SIG_RDATA, 32'd0);
        tick();
        checkOutput("irq_c1_pending", SIG_PENDING, 32'd0);
        checkOutput("irq_c1_mip", SIG_RDATA, 32'h0000_0880);
        tick();
        checkOutput("irq_c2_pending", SIG_PENDING, 32'd1);
        checkOutput("irq_c2_cause", SIG_CAUSE, 32'h8000_000B);
        trap_valid = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h2000; trap_tval = 32'd0;
        applyStimulus(12'h340, 2'b01, 32'h5555);
        checkOutput("irq_trap_target", SIG_TARGET, 32'h0000_102C);
        tick();
        trap_valid = 1'b0;
        applyStimulus(12'h340, 2'b00, 32'd0);
        checkOutput("trap_beats_write", SIG_RDATA, 32'd0);
        checkOutput("irq_c3_pending", SIG_PENDING, 32'd1);
        checkOutput("irq_trap_epc", SIG_EPC, 32'h0000_2000);
        tick();
        checkOutput("irq_c4_pending", SIG_PENDING, 32'd0);
        checkOutput("irq_c4_cause", SIG_CAUSE, 32'd0);
        applyStimulus(12'h300, 2'b00, 32'd0);
        checkOutput("irq_c4_mstatus", SIG_RDATA, 32'h0000_1880);
        irq_ext = 1'b0; mret = 1'b1;
        tick();
        mret = 1'b0;
        checkOutput("irq_c5_pending", SIG_PENDING, 32'd0);
        tick();
        checkOutput("irq_c6_pending", SIG_PENDING, 32'd1);
        checkOutput("irq_c6_cause", SIG_CAUSE, 32'h8000_0007);
        irq_sw = 1'b1;
        tick();
        checkOutput("irq_c7_cause", SIG_CAUSE, 32'h8000_0007);
        tick();
        checkOutput("irq_c8_cause", SIG_CAUSE, 32'h8000_0003);
        applyStimulus(12'h304, 2'b11, 32'h888);
        checkOutput("irq_c8_mie", SIG_RDATA, 32'h0000_0888);
        tick();
        applyStimulus(12'h304, 2'b00, 32'd0);
        checkOutput("irq_c9_pending", SIG_PENDING, 32'd1);
        tick();
        checkOutput("irq_c10_pending", SIG_PENDING, 32'd0);
        checkOutput("irq_c10_cause", SIG_CAUSE, 32'd0);
        checkOutput("irq_c10_mie", SIG_RDATA, 32'd0);
        tick();
        irq_sw = 1'b0; irq_timer = 1'b0;

`ifdef CSR_COUNTERS_EN
        $display("[TB] counters");
        writeCsr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        tick();
        readCsr("mcycle_low_wrap", 12'hB00, 32'd0);
        readCsr("mcycle_high_carry", 12'hB80, 32'd1);
`endif

        $display("[TB] reset mid-operation");
        writeCsr(12'h340, 2'b01, 32'h0000_ABCD);
        readCsr("mscratch_before_reset", 12'h340, 32'h0000_ABCD);
        applyStimulus(12'h340, 2'b00, 32'd0);
        rst_n = 1'b0;
        checkOutput("reset_async_mscratch", SIG_RDATA, 32'd0);
        tick();
        readCsr("reset_async_mstatus", 12'h300, 32'h0000_1800);
        rst_n = 1'b1;
        readCsr("reset_async_mtvec", 12'h305, 32'h0000_0200);
        tick();

        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d required=0 entries left", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
